pwm_audio_demod: RTL and testbench

Receive-side counterpart to the PWM audio mixer. It recovers sample values from a 1-bit PWM audio stream by counting high cycles over fixed PWM frames and summing 2^AVG_LOG frames per output sample. Results go out through a one-entry valid/ready buffer with overrun detection. It is used for on-chip loopback checking of the sonification output and for bench-side audio capture.

---
 rtl/pwm_audio_demod.sv | 98 +++++++++
 tb/tb_pwm_audio_demod.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_demod.sv
// Recovers audio samples from a 1-bit PWM stream by counting high cycles per frame and summing
// 2^AVG_LOG frames per sample, delivered through a one-entry valid/ready buffer with overrun flag.
module pwm_audio_demod #(
  parameter int unsigned K       = 3,
  parameter int unsigned AVG_LOG = 4,
  localparam int unsigned OW     = K + AVG_LOG + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwm_in_i,
  input  logic          sync_i,
  output logic [OW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          overrun_o,
  input  logic          clr_overrun_i
);

  logic [K-1:0]       fc_q, fc_d;
  logic [K:0]         fa_q, fa_d;
  logic [AVG_LOG-1:0] sc_q, sc_d;
  logic [OW-1:0]      sa_q, sa_d;
  logic [OW-1:0]      data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  logic          frame_done, sample_done, xfer, drop;
  logic [K:0]    fv;
  logic [OW-1:0] cs;

  assign frame_done  = (fc_q == '1);
  assign fv          = fa_q + (K+1)'(pwm_in_i);
  assign cs          = sa_q + OW'(fv);
  // A sample completing in a sync cycle is discarded.
  assign sample_done = frame_done & (sc_q == '1) & ~sync_i;
  assign xfer        = valid_q & out_ready_i;
  assign drop        = sample_done & valid_q & ~xfer;

  always_comb begin
    fc_d = fc_q + K'(1);
    fa_d = frame_done ? '0 : fv;
    sc_d = sc_q;
    sa_d = sa_q;
    if (frame_done) begin
      if (sc_q == '1) begin
        sc_d = '0;
        sa_d = '0;
      end else begin
        sc_d = sc_q + AVG_LOG'(1);
        sa_d = cs;
      end
    end
    if (sync_i) begin
      fc_d = '0;
      fa_d = '0;
      sc_d = '0;
      sa_d = '0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (sample_done && (!valid_q || xfer)) begin
      data_d  = cs;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    // A drop wins over a simultaneous clear.
    ovr_d = drop | (ovr_q & ~clr_overrun_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q    <= '0;
      fa_q    <= '0;
      sc_q    <= '0;
      sa_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      fa_q    <= fa_d;
      sc_q    <= sc_d;
      sa_q    <= sa_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_pwm_audio_demod.sv
// Bench for pwm_audio_demod: a per-sample-window counting model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pwm_audio_demod;

  localparam int K       = 3;
  localparam int AVG_LOG = 4;
  localparam int OW      = K + AVG_LOG + 1;
  localparam int SAMP    = 1 << (K + AVG_LOG);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pwm_in = 1'b0;
  logic          sync = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overrun;
  logic          clr_overrun = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  pwm_audio_demod dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_in_i     (pwm_in),
    .sync_i       (sync),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .overrun_o    (overrun),
    .clr_overrun_i(clr_overrun)
  );

  always #5 clk = ~clk;

  // Model: count highs over each SAMP-cycle window since alignment.
  int acc, idx, cs;
  bit cs_av, m_valid, m_ovr, started, xfer, drop;
  int m_data;

  always @(posedge clk) begin
    if (reset) begin
      acc = 0; idx = 0; m_valid = 0; m_data = 0; m_ovr = 0; started = 1;
    end else if (started) begin
      cs_av = 0;
      if (sync) begin
        acc = 0; idx = 0;
      end else begin
        acc = acc + int'(pwm_in);
        idx = idx + 1;
        if (idx == SAMP) begin
          cs_av = 1; cs = acc; acc = 0; idx = 0;
        end
      end
      xfer = m_valid && out_ready;
      drop = cs_av && m_valid && !xfer;
      if (cs_av && (!m_valid || xfer)) begin
        m_data = cs; m_valid = 1;
      end else if (xfer) begin
        m_valid = 0;
      end
      if (drop) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model out_valid", int'(out_valid), int'(m_valid));
      check("model overrun", int'(overrun), int'(m_ovr));
      check("model out_data", int'(out_data), m_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves the bench positioned so the next edge is sample cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // 1: constant high, always ready
    pwm_in = 1'b1; out_ready = 1'b1;
    do_reset();
    check("t1 reset valid", int'(out_valid), 0);
    check("t1 reset data", int'(out_data), 0);
    check("t1 reset overrun", int'(overrun), 0);
    run(127);
    check("t1 valid c127", int'(out_valid), 0);
    step();
    check("t1 valid c128", int'(out_valid), 1);
    check("t1 data c128", int'(out_data), 128);
    step();
    check("t1 valid c129", int'(out_valid), 0);
    run(127);
    check("t1 valid c256", int'(out_valid), 1);
    run(128);
    check("t1 valid c384", int'(out_valid), 1);
    check("t1 data c384", int'(out_data), 128);
    check("t1 overrun", int'(overrun), 0);

    // 2: constant low
    pwm_in = 1'b0;
    do_reset();
    run(128);
    check("t2 valid c128", int'(out_valid), 1);
    check("t2 data c128", int'(out_data), 0);

    // 3: 3-of-8 duty pattern
    do_reset();
    for (int i = 0; i < 256; i++) begin
      pwm_in = ((i % 8) < 3);
      step();
      if (i == 127 || i == 255) begin
        check("t3 valid", int'(out_valid), 1);
        check("t3 data", int'(out_data), 48);
      end
    end

    // 4: stalled consumer, overrun and clear
    pwm_in = 1'b1; out_ready = 1'b0;
    do_reset();
    run(128);
    check("t4 valid c128", int'(out_valid), 1);
    check("t4 data c128", int'(out_data), 128);
    run(129);
    check("t4 overrun c257", int'(overrun), 1);
    check("t4 valid c257", int'(out_valid), 1);
    run(43);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4 valid after xfer", int'(out_valid), 0);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("t4 overrun cleared", int'(overrun), 0);
    run(209);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("t4 drop beats clear", int'(overrun), 1);
    check("t4 data held", int'(out_data), 128);

    // 5: back-to-back load with a new value
    pwm_in = 1'b1; out_ready = 1'b0;
    do_reset();
    run(128);
    pwm_in = 1'b0;
    run(127);
    out_ready = 1'b1;
    step();
    check("t5 b2b valid", int'(out_valid), 1);
    check("t5 b2b data", int'(out_data), 0);
    check("t5 b2b overrun", int'(overrun), 0);
    step();
    check("t5 drained", int'(out_valid), 0);

    // 6: sync realign, then reset with a buffered sample
    pwm_in = 1'b1; out_ready = 1'b1;
    do_reset();
    run(50);
    sync = 1'b1;
    step();
    sync = 1'b0;
    run(77);
    check("t6 no sample c128", int'(out_valid), 0);
    run(50);
    check("t6 no sample c178", int'(out_valid), 0);
    step();
    check("t6 valid c179", int'(out_valid), 1);
    check("t6 data c179", int'(out_data), 128);
    out_ready = 1'b0;
    run(21);
    check("t6 valid c200", int'(out_valid), 1);
    reset = 1'b1;
    step();
    check("t6 reset valid", int'(out_valid), 0);
    check("t6 reset overrun", int'(overrun), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    run(127);
    check("t6 post reset c127", int'(out_valid), 0);
    step();
    check("t6 post reset c128", int'(out_valid), 1);
    step();
    sync = 1'b1;
    run(300);
    check("t6 sync held", int'(out_valid), 0);
    sync = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
